// File: rtl/pkt_drain_arbiter.sv
// Purpose: drains the valid-class and invalid-class packet FIFOs onto one tagged valid/ready stream using weighted round-robin.
// Latency: a pop issued in cycle N is presented on m_valid in N+2; peak throughput is one word every 2 cycles.
// Backpressure: a presented word is held stable until m_ready; no further FIFO pop is issued until that handshake.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   enable              gates new FIFO pops only; a word already fetched still completes
//   cnt_clr             synchronous clear of both forwarded-packet counters (wins over a same-cycle increment)
//   vf_* / if_*         empty flag, pop strobe and read data of the valid / invalid FIFO
//                       (read data is valid the cycle after the pop strobe)
//   m_data, m_tag       output word and its class (1 = valid class, 0 = invalid class)
//   m_valid, m_ready    output handshake
//   valid_cnt           wrapping count of forwarded valid-class words
//   invalid_cnt         wrapping count of forwarded invalid-class words
//   busy                high while a word is being fetched or presented
module pkt_drain_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int VALID_WEIGHT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cnt_clr,

  input  logic                  vf_empty,
  output logic                  vf_rd_en,
  input  logic [DATA_WIDTH-1:0] vf_rd_data,

  input  logic                  if_empty,
  output logic                  if_rd_en,
  input  logic [DATA_WIDTH-1:0] if_rd_data,

  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_tag,
  output logic                  m_valid,
  input  logic                  m_ready,

  output logic [CNT_WIDTH-1:0]  valid_cnt,
  output logic [CNT_WIDTH-1:0]  invalid_cnt,
  output logic                  busy
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  // Weight limit in the same width as the weight counter (legal weights fit in 4 bits).
  localparam logic [3:0] WMAX = 4'(VALID_WEIGHT);

  logic [1:0] state;
  logic [3:0] wcnt;       // consecutive valid-class grants since the last invalid grant
  logic       sel_valid;  // which FIFO was popped for the word now in FETCH

  logic handshake;
  logic issue_window;
  logic any_pending;
  logic issue;
  logic grant_valid;

  // ------------------------------------------------------------------
  // Issue and arbitration
  // ------------------------------------------------------------------
  always_comb begin
    handshake    = (state == ST_SEND) & m_ready;
    // A new pop may only be issued when nothing is held, or in the very
    // cycle the held word leaves; this is what keeps one word in flight.
    issue_window = (state == ST_IDLE) | handshake;
    any_pending  = ~vf_empty | ~if_empty;
    // rst gates the strobes so no word is popped during a reset cycle,
    // where it would otherwise be lost.
    issue        = ~rst & enable & issue_window & any_pending;

    // Valid class wins unless it has used up its weight while the invalid
    // FIFO is waiting; a lone non-empty FIFO always wins.
    grant_valid  = ~vf_empty & (if_empty | (wcnt < WMAX));
  end

  // grant_valid=0 with issue=1 implies the invalid FIFO is non-empty, so
  // neither strobe can ever fire against an empty FIFO.
  assign vf_rd_en = issue & grant_valid;
  assign if_rd_en = issue & ~grant_valid;

  assign m_valid  = (state == ST_SEND);
  assign busy     = (state != ST_IDLE);

  // ------------------------------------------------------------------
  // State machine
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (issue) state <= ST_FETCH;
        ST_FETCH: state <= ST_SEND;
        ST_SEND:  if (handshake) state <= issue ? ST_FETCH : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Weight counter and source select
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      sel_valid <= 1'b0;
    end else if (issue) begin
      sel_valid <= grant_valid;
      if (grant_valid) begin
        if (wcnt != WMAX) wcnt <= wcnt + 4'd1;
      end else begin
        wcnt <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Output word register
  // ------------------------------------------------------------------
  // Loaded only in FETCH, so the word stays frozen for the whole SEND
  // period regardless of what the FIFOs do meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data <= '0;
      m_tag  <= 1'b0;
    end else if (state == ST_FETCH) begin
      m_data <= sel_valid ? vf_rd_data : if_rd_data;
      m_tag  <= sel_valid;
    end
  end

  // ------------------------------------------------------------------
  // Forwarded-packet counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      valid_cnt   <= '0;
      invalid_cnt <= '0;
    end else if (handshake) begin
      if (m_tag) valid_cnt   <= valid_cnt + 1'b1;
      else       invalid_cnt <= invalid_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pkt_drain_arbiter.md
# pkt_drain_arbiter

Drains the valid-packet and invalid-packet `sync_fifo` instances that sit behind the AXI-Lite packet validator/sorter and merges them onto a single valid/ready output stream. It uses weighted round-robin arbitration, which favours the valid class while guaranteeing the invalid class is never starved. Every forwarded word carries a class tag. Per-class forwarded-packet counters are provided for software status readout.

## Interface
- `DATA_WIDTH`, 32, packet word width; matches the FIFO width.
- `VALID_WEIGHT`, 4, maximum consecutive valid-class grants while the invalid FIFO is non-empty; legal range 1..15.
- `CNT_WIDTH`, 16, width of each forwarded-packet counter.

- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when 0, no new FIFO read is issued.
- `cnt_clr` in 1: synchronous clear of both counters.
- `vf_empty` in 1: valid-FIFO empty flag.
- `vf_rd_en` out 1: valid-FIFO pop strobe.
- `vf_rd_data` in DATA_WIDTH: valid-FIFO read data, valid the cycle after `vf_rd_en`.
- `if_empty` in 1: invalid-FIFO empty flag.
- `if_rd_en` out 1: invalid-FIFO pop strobe.
- `if_rd_data` in DATA_WIDTH: invalid-FIFO read data, valid the cycle after `if_rd_en`.
- `m_data` out DATA_WIDTH: output word.
- `m_tag` out 1: 1 = valid class, 0 = invalid class.
- `m_valid` out 1: output valid.
- `m_ready` in 1: output ready.
- `valid_cnt` out CNT_WIDTH: completed output handshakes with tag 1.
- `invalid_cnt` out CNT_WIDTH: completed output handshakes with tag 0.
- `busy` out 1: high in FETCH or SEND.

## Operation
- FSM states and transitions:
  - IDLE: no packet held. Moves to FETCH when a read is issued.
  - FETCH: the popped word is captured from the selected FIFO's `rd_data` into `m_data`, and `m_tag` is set. Always moves to SEND.
  - SEND: `m_valid`=1. Stays in SEND until `m_valid & m_ready`. On handshake, moves to FETCH if a new read is issued in that same cycle, otherwise to IDLE.
- Issue condition: in IDLE, or in SEND on the handshake cycle, a read is issued when `enable`=1 and at least one FIFO is non-empty.
- `vf_rd_en` and `if_rd_en` are combinational and mutually exclusive. Neither is ever asserted while its `empty` is 1, and neither is asserted outside the issue condition.
- Arbitration uses a weight counter `wcnt` (0..VALID_WEIGHT, reset 0):
  - Both FIFOs non-empty: grant valid if `wcnt` < VALID_WEIGHT, else grant invalid.
  - Only one FIFO non-empty: grant that FIFO.
  - Each valid grant increments `wcnt`, saturating at VALID_WEIGHT.
  - Each invalid grant clears `wcnt` to 0.
- `m_data` and `m_tag` are stable from SEND entry until the handshake completes.
- Counters:
  - Each increments by 1 on an output handshake of its class and wraps modulo 2^CNT_WIDTH.
  - `cnt_clr` has priority: a handshake in the same cycle as `cnt_clr` leaves the counter at 0.
- `enable` deassertion: a packet already in FETCH or SEND completes normally. Only new issues are blocked.
- Reset mid-operation: the held or in-flight word is discarded (it has already been popped from its FIFO). State returns to IDLE.

## Timing
- Reset values:
  - `vf_rd_en`, `if_rd_en`, `m_valid`, `m_tag`, `busy` = 0.
  - `m_data` = 0.
  - `valid_cnt`, `invalid_cnt` = 0.
  - `wcnt` = 0, state = IDLE.
- Latency: a read issued in cycle N puts `m_valid` high in N+2, with data captured at the end of N+1.
- Back-to-back: a handshake plus a new issue in cycle M gives `m_valid`=0 in M+1 and `m_valid`=1 in M+2. Peak throughput is 1 word per 2 cycles.
- `m_valid` never drops without a handshake, except on `rst`.
- Counter outputs update the cycle after the handshake or clear.
- `empty` flags are sampled in the issue cycle only.

## Test plan
- Reset, then only the valid FIFO is loaded with 0xA5000001..0xA5000003, with `m_ready`=1: expect 3 words in order, tag 1, `m_valid` at cycles N+2, N+4 and N+6, `valid_cnt`=3, `invalid_cnt`=0.
- Both FIFOs each loaded with 10 words, VALID_WEIGHT=4, `m_ready`=1: expect tag sequence 1,1,1,1,0,1,1,1,1,0,… and no read strobe ever asserted while its FIFO is empty.
- Output backpressure: hold `m_ready`=0 for 5 cycles with a word in SEND: expect `m_data`/`m_tag` stable, no further `rd_en`, and the handshake completing on the first cycle `m_ready`=1.
- `enable` dropped in the FETCH cycle: expect that word delivered, then IDLE with no `rd_en` while `enable`=0, and issue resuming the cycle `enable` returns to 1.
- `cnt_clr` asserted in the same cycle as a tag-1 handshake, with `valid_cnt`=7: expect `valid_cnt`=0 next cycle. Separately, CNT_WIDTH=4 with 17 valid packets: expect `valid_cnt`=1.
- `rst` asserted while in SEND: expect all outputs at their reset values the next cycle and the held word never presented.
